// File: rtl/bias_ctrl_if.sv
// bias_ctrl_if -- signal bundle between the bias sequencing controller and its
// neighbours (DMA stream demux, bias buffer, conv-engine group scheduler).
//   master : the surrounding system (drives config, stream valid, group requests)
//   slave  : bias_ctrl (drives ready/strobes, read address, status flags)
// Signals:
//   soft_clr        synchronous abort
//   cfg_start       one-cycle config pulse, qualifies cfg_grp_num
//   cfg_grp_num[8]  number of 8-channel output groups (1..128 legal)
//   cfg_err         sticky illegal-config flag
//   bias_in_vld     bias word present on the DMA stream
//   bias_in_rdy     controller accepts a bias word
//   stream_bias_vld buffer write strobe
//   write_finish    last bias word of the layer
//   bias_loaded     layer bias resident in the buffer
//   grp_req         request for the next group's bias
//   bias_rd_addr[7] buffer read address (one group per address)
//   bias_vld        buffer output valid for the current group
//   req_err         sticky out-of-order request flag
//   layer_done      one-cycle end-of-layer pulse
interface bias_ctrl_if;
  logic       soft_clr;
  logic       cfg_start;
  logic [7:0] cfg_grp_num;
  logic       cfg_err;
  logic       bias_in_vld;
  logic       bias_in_rdy;
  logic       stream_bias_vld;
  logic       write_finish;
  logic       bias_loaded;
  logic       grp_req;
  logic [6:0] bias_rd_addr;
  logic       bias_vld;
  logic       req_err;
  logic       layer_done;

  modport master (
    output soft_clr, cfg_start, cfg_grp_num, bias_in_vld, grp_req,
    input  cfg_err, bias_in_rdy, stream_bias_vld, write_finish, bias_loaded,
           bias_rd_addr, bias_vld, req_err, layer_done
  );

  modport slave (
    input  soft_clr, cfg_start, cfg_grp_num, bias_in_vld, grp_req,
    output cfg_err, bias_in_rdy, stream_bias_vld, write_finish, bias_loaded,
           bias_rd_addr, bias_vld, req_err, layer_done
  );
endinterface

// File: rtl/bias_ctrl.sv
// bias_ctrl -- per-layer bias buffer sequencer.
// Latches a layer configuration, gates 4*grp_num 64-bit bias words into the
// buffer (flagging the last one), then serves one 8-channel group per request,
// driving the buffer read address and a valid strobe aligned to the buffer's
// read latency.
// Parameters:
//   RD_LAT   buffer read latency in sclk edges, 1..4
// Ports:
//   sclk     clock
//   s_rst_n  asynchronous active-low reset
//   bus      bias_ctrl_if.slave (config, stream handshake, read side, status)
module bias_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic           sclk,
  input  logic           s_rst_n,
  bias_ctrl_if.slave     bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] READY   = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0] state;
  logic [7:0] grp_num;
  logic [7:0] grp_cnt;
  logic [8:0] word_cnt;
  // Index of the final word (4*grp_num-1); kept as total-1 so a full
  // 128-group layer (512 words) still fits in 9 bits.
  logic [8:0] last_idx;
  logic [2:0] lat_cnt;
  logic [6:0] rd_addr_q;
  logic       bias_in_rdy_q;
  logic       bias_loaded_q;
  logic       bias_vld_q;
  logic       layer_done_q;
  logic       cfg_err_q;
  logic       req_err_q;

  logic cfg_legal;
  logic accept;
  logic last_word;
  logic req_ok;
  logic last_grp;

  assign cfg_legal = (bus.cfg_grp_num != 8'd0) && (bus.cfg_grp_num <= 8'd128);
  assign accept    = bus.bias_in_vld & bias_in_rdy_q;
  assign last_word = (word_cnt == last_idx);
  // The bias_vld cycle already sits in READY; a request there is still too early.
  assign req_ok    = (state == READY) && !bias_vld_q;
  assign last_grp  = (grp_cnt == grp_num - 8'd1);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state         <= IDLE;
      grp_num       <= '0;
      grp_cnt       <= '0;
      word_cnt      <= '0;
      last_idx      <= '0;
      lat_cnt       <= '0;
      rd_addr_q     <= '0;
      bias_in_rdy_q <= 1'b0;
      bias_loaded_q <= 1'b0;
      bias_vld_q    <= 1'b0;
      layer_done_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
      req_err_q     <= 1'b0;
    end else if (bus.soft_clr) begin
      state         <= IDLE;
      grp_num       <= '0;
      grp_cnt       <= '0;
      word_cnt      <= '0;
      last_idx      <= '0;
      lat_cnt       <= '0;
      rd_addr_q     <= '0;
      bias_in_rdy_q <= 1'b0;
      bias_loaded_q <= 1'b0;
      bias_vld_q    <= 1'b0;
      layer_done_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      bias_vld_q   <= 1'b0;
      layer_done_q <= 1'b0;

      if (bus.grp_req && !req_ok) begin
        req_err_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            if (cfg_legal) begin
              grp_num       <= bus.cfg_grp_num;
              last_idx      <= {7'(bus.cfg_grp_num - 8'd1), 2'b11};
              word_cnt      <= '0;
              grp_cnt       <= '0;
              bias_in_rdy_q <= 1'b1;
              state         <= LOAD;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            word_cnt <= word_cnt + 9'd1;
            if (last_word) begin
              bias_in_rdy_q <= 1'b0;
              bias_loaded_q <= 1'b1;
              state         <= READY;
            end
          end
        end

        READY: begin
          if (req_ok && bus.grp_req) begin
            rd_addr_q <= grp_cnt[6:0];
            lat_cnt   <= 3'(RD_LAT);
            state     <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (lat_cnt == 3'd1) begin
            bias_vld_q <= 1'b1;
            grp_cnt    <= grp_cnt + 8'd1;
            state      <= last_grp ? DONE : READY;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        DONE: begin
          layer_done_q  <= 1'b1;
          bias_loaded_q <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bias_in_rdy     = bias_in_rdy_q;
  assign bus.stream_bias_vld = accept;
  assign bus.write_finish    = accept & last_word;
  assign bus.bias_loaded     = bias_loaded_q;
  assign bus.bias_rd_addr    = rd_addr_q;
  assign bus.bias_vld        = bias_vld_q;
  assign bus.layer_done      = layer_done_q;
  assign bus.cfg_err         = cfg_err_q;
  assign bus.req_err         = req_err_q;

endmodule

// File: tb/tb_bias_ctrl.sv
// Bench for bias_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share one
// stimulus stream and are each compared every cycle against an event-schedule
// model; a bias-buffer stand-in checks the group data seen at bias_vld.
module tb_bias_ctrl;
  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        soft_clr = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_grp_num = '0;
  logic        bias_in_vld = 1'b0;
  logic        grp_req = 1'b0;
  logic [63:0] bias_data = '0;

  always #5 sclk = ~sclk;

  bias_ctrl_if b1 ();
  bias_ctrl_if b3 ();

  assign b1.soft_clr    = soft_clr;
  assign b1.cfg_start   = cfg_start;
  assign b1.cfg_grp_num = cfg_grp_num;
  assign b1.bias_in_vld = bias_in_vld;
  assign b1.grp_req     = grp_req;
  assign b3.soft_clr    = soft_clr;
  assign b3.cfg_start   = cfg_start;
  assign b3.cfg_grp_num = cfg_grp_num;
  assign b3.bias_in_vld = bias_in_vld;
  assign b3.grp_req     = grp_req;

  bias_ctrl #(.RD_LAT(1)) dut1 (.sclk(sclk), .s_rst_n(s_rst_n), .bus(b1));
  bias_ctrl #(.RD_LAT(3)) dut3 (.sclk(sclk), .s_rst_n(s_rst_n), .bus(b3));

  // ---------------- reference model: layer progress + scheduled events ----
  typedef struct {
    bit active, rdy, loaded, vld, done, cfg_err, req_err;
    int grp_num, total, words, served, addr, vld_at, done_at;
  } model_t;

  function automatic model_t zero_m();
    model_t z;
    z = '{default: 0};
    z.vld_at  = -1;
    z.done_at = -1;
    return z;
  endfunction

  // e = index of the clock edge being taken; result is what holds after it.
  function automatic model_t step(model_t m, int lat, int e);
    model_t n;
    int g;
    n = m;
    n.vld  = 0;
    n.done = 0;
    if (soft_clr) return zero_m();
    g = int'(cfg_grp_num);
    if (cfg_start && !m.active) begin
      if (g >= 1 && g <= 128) begin
        n.active = 1; n.grp_num = g; n.total = 4 * g;
        n.words = 0; n.served = 0; n.rdy = 1;
      end else n.cfg_err = 1;
    end
    if (m.rdy && bias_in_vld) begin
      n.words = m.words + 1;
      if (n.words == m.total) begin n.rdy = 0; n.loaded = 1; end
    end
    if (grp_req) begin
      if (m.loaded && m.vld_at < 0 && m.done_at < 0 && !m.vld && m.served < m.grp_num) begin
        n.addr = m.served;
        n.vld_at = e + lat;
      end else n.req_err = 1;
    end
    if (m.vld_at == e) begin
      n.vld = 1; n.served = m.served + 1; n.vld_at = -1;
      if (n.served == m.grp_num) n.done_at = e + 1;
    end
    if (m.done_at == e) begin
      n.done = 1; n.loaded = 0; n.active = 0; n.done_at = -1;
    end
    return n;
  endfunction

  model_t m1 = zero_m();
  model_t m3 = zero_m();
  int cyc = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  always @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      m1 <= zero_m();
      m3 <= zero_m();
    end else begin
      m1 <= step(m1, 1, cyc);
      m3 <= step(m3, 3, cyc);
    end

  // ---------------- bias buffer stand-in and expected word record ---------
  logic [63:0]  ref_w [512];
  logic [63:0]  mem   [512];
  int           wp;
  logic [255:0] pipe1;
  logic [255:0] pipe3 [3];

  always @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) wp <= 0;
    else begin
      if (soft_clr) wp <= 0;
      else if (b1.stream_bias_vld) begin
        mem[wp] <= bias_data;
        wp <= b1.write_finish ? 0 : wp + 1;
      end
      if (m1.rdy && bias_in_vld && !soft_clr) ref_w[m1.words] <= bias_data;
    end

  function automatic logic [255:0] mem_grp(input logic [6:0] a);
    int b;
    b = 4 * int'(a);
    return {mem[b+3], mem[b+2], mem[b+1], mem[b]};
  endfunction

  function automatic logic [255:0] ref_grp(input int a);
    int b;
    b = 4 * a;
    return {ref_w[b+3], ref_w[b+2], ref_w[b+1], ref_w[b]};
  endfunction

  always @(posedge sclk) begin
    pipe1    <= mem_grp(b1.bias_rd_addr);
    pipe3[0] <= mem_grp(b3.bias_rd_addr);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  // ---------------- checking ----------------------------------------------
  int checks = 0;
  int errors = 0;
  int writes, wf_cnt, wf_at, vld1, vld3, done1, done3, req_cyc, lat1, lat3;

  task automatic chk(input string name, input int d, input logic [255:0] got,
                     input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (lat%0d) at cycle %0d: got %0h want %0h", name, d, cyc, got, want);
    end
  endtask

  task automatic cmp(input int d, input model_t m, input logic rdy, input logic svld,
                     input logic wf, input logic ld, input logic [6:0] addr,
                     input logic vld, input logic dn, input logic ce, input logic re,
                     input logic [255:0] ch);
    chk("bias_in_rdy",     d, rdy,  m.rdy);
    chk("stream_bias_vld", d, svld, m.rdy & bias_in_vld);
    chk("write_finish",    d, wf,   m.rdy & bias_in_vld & (m.words == m.total - 1));
    chk("bias_loaded",     d, ld,   m.loaded);
    chk("bias_rd_addr",    d, addr, m.addr[6:0]);
    chk("bias_vld",        d, vld,  m.vld);
    chk("layer_done",      d, dn,   m.done);
    chk("cfg_err",         d, ce,   m.cfg_err);
    chk("req_err",         d, re,   m.req_err);
    if (m.vld) chk("bias_data", d, ch, ref_grp(m.addr));
  endtask

  task automatic tick();
    @(posedge sclk);
    #2;
  endtask

  task automatic clr_counts();
    writes = 0; wf_cnt = 0; wf_at = 0; vld1 = 0; vld3 = 0; done1 = 0; done3 = 0;
  endtask

  task automatic do_cfg(input int g);
    cfg_grp_num = 8'(g);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // mode 0: continuous, 1: toggling, 2: random gaps
  task automatic stream(input int mode);
    int n;
    n = 0;
    while (!b1.bias_loaded && n < 3000) begin
      bias_in_vld = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : ($urandom_range(0, 2) != 0);
      bias_data = {$urandom, $urandom};
      tick();
      n++;
    end
    bias_in_vld = 1'b0;
    chk("load_within_budget", 0, n < 3000, 1'b1);
  endtask

  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      grp_req = 1'b1;
      tick();
      grp_req = 1'b0;
      repeat (5) tick();
    end
  endtask

  task automatic pulse_clr();
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_counts();
    req_cyc = 0; lat1 = 0; lat3 = 0;
    fork
      forever begin
        @(negedge sclk);
        cmp(1, m1, b1.bias_in_rdy, b1.stream_bias_vld, b1.write_finish, b1.bias_loaded,
            b1.bias_rd_addr, b1.bias_vld, b1.layer_done, b1.cfg_err, b1.req_err, pipe1);
        cmp(3, m3, b3.bias_in_rdy, b3.stream_bias_vld, b3.write_finish, b3.bias_loaded,
            b3.bias_rd_addr, b3.bias_vld, b3.layer_done, b3.cfg_err, b3.req_err, pipe3[2]);
        if (grp_req) req_cyc = cyc;
        if (b1.stream_bias_vld) begin
          writes++;
          if (b1.write_finish) wf_at = writes;
        end
        if (b1.write_finish) wf_cnt++;
        if (b1.bias_vld) begin vld1++; lat1 = cyc - req_cyc; end
        if (b3.bias_vld) begin vld3++; lat3 = cyc - req_cyc; end
        if (b1.layer_done) done1++;
        if (b3.layer_done) done3++;
      end
    join_none

    repeat (3) tick();
    chk("rst_rdy",    1, b1.bias_in_rdy, 1'b0);
    chk("rst_loaded", 3, b3.bias_loaded, 1'b0);
    s_rst_n = 1'b1;
    tick();

    // nominal: 3 groups
    clr_counts();
    do_cfg(3);
    stream(0);
    chk("nom_writes", 1, writes, 12);
    chk("nom_wf_word", 1, wf_at, 12);
    chk("nom_wf_count", 1, wf_cnt, 1);
    chk("nom_loaded", 1, b1.bias_loaded, 1'b1);
    for (int i = 0; i < 3; i++) begin
      grp_req = 1'b1;
      tick();
      grp_req = 1'b0;
      chk("nom_addr", 1, b1.bias_rd_addr, 7'(i));
      chk("nom_addr", 3, b3.bias_rd_addr, 7'(i));
      repeat (5) tick();
    end
    chk("nom_vld_count", 1, vld1, 3);
    chk("nom_vld_count", 3, vld3, 3);
    chk("nom_latency", 1, lat1, 2);
    chk("nom_latency", 3, lat3, 4);
    chk("nom_done", 1, done1, 1);
    chk("nom_done", 3, done3, 1);

    // throttled stream: 2 groups
    clr_counts();
    do_cfg(2);
    stream(1);
    chk("thr_writes", 1, writes, 8);
    chk("thr_wf_word", 1, wf_at, 8);
    tick();
    chk("thr_rdy_low", 1, b1.bias_in_rdy, 1'b0);
    serve(2);
    chk("thr_done", 3, done3, 1);

    // illegal configuration
    do_cfg(0);
    chk("cfg0_err", 1, b1.cfg_err, 1'b1);
    tick();
    chk("cfg0_rdy", 1, b1.bias_in_rdy, 1'b0);
    do_cfg(200);
    chk("cfg200_err", 3, b3.cfg_err, 1'b1);
    pulse_clr();
    chk("clr_cfg_err", 1, b1.cfg_err, 1'b0);

    // protocol errors: request during LOAD and during RD_WAIT, cfg in READY
    clr_counts();
    do_cfg(1);
    grp_req = 1'b1;
    bias_in_vld = 1'b1;
    bias_data = {$urandom, $urandom};
    tick();
    grp_req = 1'b0;
    chk("req_in_load", 1, b1.req_err, 1'b1);
    stream(0);
    do_cfg(5);
    chk("cfg_in_ready_ignored", 1, b1.bias_in_rdy, 1'b0);
    grp_req = 1'b1;
    tick();
    tick();
    grp_req = 1'b0;
    repeat (6) tick();
    chk("single_vld", 1, vld1, 1);
    chk("single_vld", 3, vld3, 1);
    chk("err_done", 1, done1, 1);
    pulse_clr();

    // abort mid-load, then a fresh one-group layer
    clr_counts();
    do_cfg(2);
    bias_in_vld = 1'b1;
    repeat (5) begin
      bias_data = {$urandom, $urandom};
      tick();
    end
    soft_clr = 1'b1;
    bias_in_vld = 1'b0;
    tick();
    soft_clr = 1'b0;
    chk("abort_writes", 1, writes, 5);
    chk("abort_loaded", 1, b1.bias_loaded, 1'b0);
    clr_counts();
    do_cfg(1);
    stream(0);
    serve(1);
    chk("fresh_writes", 1, writes, 4);
    chk("fresh_done", 3, done3, 1);

    // asynchronous reset while a read is outstanding
    do_cfg(2);
    stream(2);
    serve(1);
    clr_counts();
    grp_req = 1'b1;
    tick();
    grp_req = 1'b0;
    s_rst_n = 1'b0;
    #1;
    chk("arst_addr", 1, b1.bias_rd_addr, 7'd0);
    chk("arst_loaded", 3, b3.bias_loaded, 1'b0);
    tick();
    tick();
    s_rst_n = 1'b1;
    repeat (6) tick();
    chk("arst_no_vld", 1, vld1, 0);
    chk("arst_no_vld", 3, vld3, 0);

    // full-size layer
    clr_counts();
    do_cfg(128);
    stream(2);
    chk("max_writes", 1, writes, 512);
    chk("max_wf_word", 1, wf_at, 512);
    serve(128);
    chk("max_last_addr", 1, b1.bias_rd_addr, 7'd127);
    chk("max_last_addr", 3, b3.bias_rd_addr, 7'd127);
    chk("max_done", 1, done1, 1);

    // randomized layers with stray requests, configs and aborts
    for (int layer = 0; layer < 10; layer++) begin
      int g;
      g = ($urandom_range(0, 8) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(129, 255))
                                      : $urandom_range(1, 8);
      clr_counts();
      do_cfg(g);
      if (g >= 1 && g <= 128) stream(2);
      for (int c = 0; c < 300 && done1 == 0; c++) begin
        grp_req = ($urandom_range(0, 2) == 0);
        soft_clr = ($urandom_range(0, 150) == 0);
        cfg_start = ($urandom_range(0, 40) == 0);
        cfg_grp_num = 8'($urandom_range(0, 255));
        bias_in_vld = ($urandom_range(0, 1) == 0);
        bias_data = {$urandom, $urandom};
        tick();
      end
      grp_req = 1'b0;
      cfg_start = 1'b0;
      bias_in_vld = 1'b0;
      soft_clr = 1'b0;
      repeat (6) tick();
      pulse_clr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bias_ctrl.md
# bias_ctrl

Sequencing controller for the per-layer bias buffer. It accepts a layer configuration, then gates the incoming 64-bit bias stream into the buffer and flags the final word so the buffer's write counter realigns for the next layer. It then serves the convolution engine's bias requests one output-channel group (8 channels) at a time: it drives the buffer read address and emits a valid strobe aligned with the buffer's read latency. It sits between the DMA stream demux, the bias buffer and the conv engine's group scheduler.

## Interface
- RD_LAT, 1, read latency of the bias buffer in sclk edges (address register to data valid); legal range 1..4
- sclk  in  1  clock
- s_rst_n  in  1  reset, asynchronous, active-low
- soft_clr  in  1  synchronous abort; returns the block to IDLE
- cfg_start  in  1  one-cycle pulse; latches cfg_grp_num
- cfg_grp_num  in  8  number of 8-channel output groups in the layer; legal range 1..128
- cfg_err  out  1  sticky; set when cfg_start arrives with an illegal cfg_grp_num; cleared by soft_clr
- bias_in_vld  in  1  bias word present on the stream from the DMA demux
- bias_in_rdy  out  1  controller accepts a bias word
- stream_bias_vld  out  1  write strobe to the buffer; equals bias_in_vld & bias_in_rdy (combinational)
- write_finish  out  1  high together with stream_bias_vld on the last bias word of the layer
- bias_loaded  out  1  high from load completion until layer_done
- grp_req  in  1  one-cycle pulse from the conv engine requesting the next group's bias
- bias_rd_addr  out  7  registered read address to the buffer
- bias_vld  out  1  one-cycle pulse; buffer outputs bias_ch0..7 are valid for the current group
- req_err  out  1  sticky; set when grp_req arrives outside READY; cleared by soft_clr
- layer_done  out  1  one-cycle pulse after the last group's bias_vld

## Operation
- States: IDLE, LOAD, READY, RD_WAIT, DONE.
- Reset values: state IDLE; all outputs 0; internal counters 0.
- IDLE:
  - On cfg_start with cfg_grp_num in 1..128: latch grp_num, set total = 4*grp_num (9 bits, maximum 512), clear word_cnt and grp_cnt, go to LOAD.
  - On cfg_start with an illegal value (0 or >128): set cfg_err and stay in IDLE.
- LOAD:
  - bias_in_rdy = 1.
  - Each accepted word increments word_cnt.
  - The accepted word with word_cnt == total-1 asserts write_finish in the same cycle. The next state is READY and bias_loaded is set.
- READY:
  - On grp_req: register bias_rd_addr <= grp_cnt[6:0], load the latency counter with RD_LAT, go to RD_WAIT.
- RD_WAIT:
  - When the latency counter expires: bias_vld = 1 for one cycle, grp_cnt increments.
  - If grp_cnt was grp_num-1, go to DONE; otherwise go to READY.
- DONE:
  - layer_done = 1 for one cycle, bias_loaded cleared, go to IDLE.
- cfg_start outside IDLE is ignored, with no flag.
- grp_req in any state other than READY is ignored and sets req_err. This includes a grp_req in the same cycle as bias_vld.
- soft_clr has priority over all transitions. It forces IDLE, zeroes the outputs and counters, and clears both error flags.
- bias_rd_addr holds its last value between requests.

## Timing
- Stream path has zero latency. bias_in_rdy is registered from state. stream_bias_vld and write_finish are combinational from bias_in_vld.
- Back-to-back words are accepted every cycle. Gaps in bias_in_vld only stall word_cnt.
- If grp_req is sampled at edge t:
  - bias_rd_addr is valid after edge t.
  - bias_vld is high in the cycle after edge t+RD_LAT.
  - With RD_LAT=1, there are 2 cycles from grp_req to bias_vld.
- The earliest next grp_req is the cycle after bias_vld. Group throughput is one group per RD_LAT+2 cycles.
- layer_done is high in the cycle after the last bias_vld. IDLE accepts cfg_start in the following cycle.
- An asynchronous s_rst_n assertion at any point returns the block to IDLE immediately, with all outputs 0.

## Test plan
- Nominal: cfg_grp_num=3.
  - Stream 12 words continuously → 12 stream_bias_vld; write_finish only on word 12; bias_loaded=1.
  - Issue 3 grp_req → bias_rd_addr 0,1,2; each bias_vld 2 cycles after its request (RD_LAT=1); layer_done after the third.
- Throttled stream: cfg_grp_num=2, bias_in_vld toggling 1/0 → exactly 8 writes; write_finish on the 8th accepted word; bias_in_rdy low after it.
- Boundaries:
  - cfg_grp_num=128 → 512 words; write_finish on word 512; final bias_rd_addr=127.
  - cfg_grp_num=0 → cfg_err=1, state stays IDLE, bias_in_rdy=0.
- Protocol errors:
  - grp_req during LOAD, and again during RD_WAIT → req_err=1, no extra bias_vld, grp_cnt unchanged.
  - cfg_start during READY → ignored.
- Abort: soft_clr after word 5 of 8 → IDLE, all outputs 0.
  - A fresh cfg_grp_num=1 load of 4 words then completes normally.
  - s_rst_n pulsed in RD_WAIT → no bias_vld emitted.
- Latency sweep: RD_LAT=3 → bias_vld exactly 4 cycles after grp_req; the data on bias_ch0..7 matches the loaded words for that group.
